div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 512: operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1100: maximum cycles to wait for div_done.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each: requester 0/1 presents a division.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each: request accepted this cycle.
REQ-007 SHALL have ports req0_n/req1_n and req0_d/req1_d, input, WIDTH each: dividend and divisor.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, and rsp0_ready/rsp1_ready, input, 1 each: response handshake.
REQ-009 SHALL have ports rsp_q and rsp_r, output, WIDTH each; rsp_err, output, 1: shared response payload.
REQ-010 SHALL have ports div_start, output, 1; div_q_in, div_m_in, div_a_in, output, WIDTH each: divider launch and operands.
REQ-011 SHALL have ports div_done, input, 1; div_q, div_r, input, WIDTH each: divider completion and results.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: when any reqX_valid is high, SHALL grant one requester, assert that reqX_ready for exactly that cycle, latch n/d and grant id, and go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: when both are valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-015 ISSUE: SHALL assert div_start for exactly one cycle with div_q_in=n, div_m_in=d, div_a_in=0, clear the timeout counter, and go to WAIT.
REQ-016 WAIT: SHALL capture div_q/div_r on the first cycle div_done=1, set rsp_err=0, and go to RESP; the timeout counter SHALL increment each cycle.
REQ-017 If the counter reaches TIMEOUT without div_done, SHALL go to RESP with rsp_q=0, rsp_r=0, rsp_err=1.
REQ-018 RESP: SHALL hold rspX_valid high for the granted id only, with stable payload, until rspX_ready=1; then go to IDLE.
REQ-019 Minimum latency from the req handshake to rsp_valid SHALL be 3 cycles + divider latency.
REQ-020 Only one request SHALL be outstanding; reqX_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-021 A div_done seen outside WAIT SHALL be ignored.
REQ-022 If rspX_ready is already high when rspX_valid rises, the response SHALL complete in that cycle.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE and clear all outputs, latched operands, the counter and the round-robin pointer to 0.
REQ-024 Reset mid-operation SHALL abandon any in-flight division with no response issued; a later div_done SHALL be ignored per REQ-021.

Configuration
REQ-025 With macro DIV_ZERO_CHECK_EN defined, a granted request with d=0 SHALL skip ISSUE/WAIT, go directly to RESP with rsp_q=all ones, rsp_r=n, rsp_err=1, and SHALL NOT pulse div_start.
REQ-026 Without DIV_ZERO_CHECK_EN, d=0 SHALL be issued to the divider like any other request.

Verification
REQ-027 Single request: req0 n=100, d=7; divider returns q=14, r=2 -> rsp0_valid with rsp_q=14, rsp_r=2, rsp_err=0; one div_start pulse.
REQ-028 Contention: req0 and req1 held valid continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-029 Timeout: divider never asserts div_done -> after TIMEOUT cycles, rsp_err=1 with rsp_q=0, rsp_r=0.
REQ-030 Backpressure: rsp1_ready held 0 for 20 cycles -> rsp1_valid and payload stay stable; reqX_ready stays 0 throughout.
REQ-031 Reset during WAIT: rst asserted for 1 cycle, then a stale div_done -> FSM in IDLE, no rsp_valid asserted.
REQ-032 With DIV_ZERO_CHECK_EN: req0 n=55, d=0 -> no div_start; rsp_q=all ones, rsp_r=55, rsp_err=1.

Source files
------------

// File: rtl/div_sched.sv
// Arbitrates two requesters onto one external divider and returns results with a timeout guard.
// Optional macro DIV_ZERO_CHECK_EN answers d=0 requests locally without launching the divider.
module div_sched #(
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 1100
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_n,
    input  logic [WIDTH-1:0] req0_d,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_n,
    input  logic [WIDTH-1:0] req1_d,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_err,

    output logic             div_start,
    output logic [WIDTH-1:0] div_q_in,
    output logic [WIDTH-1:0] div_m_in,
    output logic [WIDTH-1:0] div_a_in,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_gnt_id;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_err;
    logic             r_div_start;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [CW-1:0]    r_cnt;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt_any;
    logic [WIDTH-1:0] w_req_n;
    logic [WIDTH-1:0] w_req_d;
    logic             w_rsp_fire;
    logic             w_timeout;

    // Ready is combinational so the grant lands in the same cycle valid is seen;
    // r_rr_ptr names the requester that wins a tie.
    assign w_gnt0    = (r_state == IDLE) && !rst && req0_valid && (!req1_valid || !r_rr_ptr);
    assign w_gnt1    = (r_state == IDLE) && !rst && req1_valid && (!req0_valid ||  r_rr_ptr);
    assign w_gnt_any = w_gnt0 || w_gnt1;
    assign w_req_n   = w_gnt1 ? req1_n : req0_n;
    assign w_req_d   = w_gnt1 ? req1_d : req0_d;

    assign w_rsp_fire = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);
    assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_gnt_id     <= 1'b0;
            r_n          <= '0;
            r_d          <= '0;
            r_q          <= '0;
            r_r          <= '0;
            r_err        <= 1'b0;
            r_div_start  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_n      <= w_req_n;
                        r_d      <= w_req_d;
                        r_gnt_id <= w_gnt1;
                        r_rr_ptr <= !w_gnt1;
`ifdef DIV_ZERO_CHECK_EN
                        if (w_req_d == '0) begin
                            r_q          <= '1;
                            r_r          <= w_req_n;
                            r_err        <= 1'b1;
                            r_rsp0_valid <= !w_gnt1;
                            r_rsp1_valid <= w_gnt1;
                            r_state      <= RESP;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= ISSUE;
                        end
`else
                        r_div_start <= 1'b1;
                        r_state     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    r_div_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (div_done) begin
                        r_q          <= div_q;
                        r_r          <= div_r;
                        r_err        <= 1'b0;
                        r_rsp0_valid <= !r_gnt_id;
                        r_rsp1_valid <= r_gnt_id;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_q          <= '0;
                        r_r          <= '0;
                        r_err        <= 1'b1;
                        r_rsp0_valid <= !r_gnt_id;
                        r_rsp1_valid <= r_gnt_id;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_q      = r_q;
    assign rsp_r      = r_r;
    assign rsp_err    = r_err;
    assign div_start  = r_div_start;
    assign div_q_in   = r_n;
    assign div_m_in   = r_d;
    assign div_a_in   = '0;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: randomized requests, a divider stub with random latency or hang,
// and a negedge monitor that checks arbitration, handshakes, operands and responses.
module tb_div_sched;

    localparam int W   = 64;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_n, req0_d, req1_n, req1_d;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_q, rsp_r;
    logic         rsp_err;
    logic         div_start, div_done;
    logic [W-1:0] div_q_in, div_m_in, div_a_in, div_q, div_r;

    div_sched #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
        .div_start(div_start), .div_q_in(div_q_in), .div_m_in(div_m_in), .div_a_in(div_a_in),
        .div_done(div_done), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        bit           hang;
    } req_t;

    typedef struct {
        bit           id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           err;
    } rsp_t;

    req_t rq0[$];
    req_t rq1[$];
    rsp_t exp_q[$];
    bit   hang_q[$];
    bit   grant_log[$];

    int checks = 0;
    int errors = 0;

    bit           outstanding = 1'b0;
    bit           cur_id, started, expect_start;
    bit           rr_ptr = 1'b0;
    logic [W-1:0] cur_n, cur_d;
    bit           bp1 = 1'b0;

    bit           dv_busy = 1'b0;
    int           dv_left;
    logic [W-1:0] dv_q, dv_r;
    bit           stale_pending = 1'b0;

    bit           pv0 = 1'b0, pv1 = 1'b0;
    logic [W-1:0] pq, pr;
    bit           perr;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return {$urandom, $urandom};
    endfunction

    // Request/response-ready driver: inputs change only 1ns after the rising edge.
    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_n = '0; req0_d = '0; req1_n = '0; req1_d = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            req0_valid = (rq0.size() > 0);
            if (rq0.size() > 0) begin
                req0_n = rq0[0].n;
                req0_d = rq0[0].d;
            end
            req1_valid = (rq1.size() > 0);
            if (rq1.size() > 0) begin
                req1_n = rq1[0].n;
                req1_d = rq1[0].d;
            end
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = bp1 ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor, reference model and divider stub, all on the falling edge.
    initial begin
        div_done = 1'b0; div_q = '0; div_r = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding   = 1'b0;
                rr_ptr        = 1'b0;
                exp_q.delete();
                hang_q.delete();
                dv_busy       = 1'b0;
                pv0           = 1'b0;
                pv1           = 1'b0;
                stale_pending = 1'b1;
                div_done      = 1'b0;
                continue;
            end

            // divider stub outputs for the next rising edge
            div_done = 1'b0;
            if (dv_busy) begin
                dv_left--;
                if (dv_left == 0) begin
                    div_done = 1'b1;
                    div_q    = dv_q;
                    div_r    = dv_r;
                    dv_busy  = 1'b0;
                end
            end else if (!outstanding && (stale_pending || $urandom_range(0, 7) == 0)) begin
                div_done      = 1'b1;
                div_q         = rnd_w();
                div_r         = rnd_w();
                stale_pending = 1'b0;
            end

            // arbitration and single-outstanding rule
            if (outstanding) begin
                chk("req_ready_busy", W'({req1_ready, req0_ready}), '0);
            end else begin
                chk("req_ready_arb", W'({req1_ready, req0_ready}),
                    W'({req1_valid && (!req0_valid || rr_ptr),
                        req0_valid && (!req1_valid || !rr_ptr)}));
            end

            // response legality and stability
            if (!outstanding)
                chk("rsp_valid_idle", W'({rsp1_valid, rsp0_valid}), '0);
            else
                chk("rsp_valid_wrong_id", W'({rsp1_valid, rsp0_valid} & (cur_id ? 2'b01 : 2'b10)), '0);
            if (pv0 || pv1) begin
                chk("rsp_hold_valid", W'({rsp1_valid, rsp0_valid}), W'({pv1, pv0}));
                chk("rsp_hold_q", rsp_q, pq);
                chk("rsp_hold_r", rsp_r, pr);
                chk("rsp_hold_err", W'(rsp_err), W'(perr));
            end

            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", W'(1), W'(0));
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", W'(rsp1_valid && rsp1_ready), W'(e.id));
                    chk("rsp_q", rsp_q, e.q);
                    chk("rsp_r", rsp_r, e.r);
                    chk("rsp_err", W'(rsp_err), W'(e.err));
                    if (expect_start) chk("div_start_seen", W'(started), W'(1));
                end
                outstanding = 1'b0;
                pv0 = 1'b0;
                pv1 = 1'b0;
            end else begin
                pv0  = rsp0_valid;
                pv1  = rsp1_valid;
                pq   = rsp_q;
                pr   = rsp_r;
                perr = rsp_err;
            end

            // divider launch
            if (div_start) begin
                chk("div_start_expected", W'({started, hang_q.size() == 0}), '0);
                if (!started && hang_q.size() > 0) begin
                    bit h;
                    started = 1'b1;
                    h = hang_q.pop_front();
                    chk("div_q_in", div_q_in, cur_n);
                    chk("div_m_in", div_m_in, cur_d);
                    chk("div_a_in", div_a_in, '0);
                    if (div_m_in == '0) begin
                        dv_q = '1;
                        dv_r = div_q_in;
                    end else begin
                        dv_q = div_q_in / div_m_in;
                        dv_r = div_q_in % div_m_in;
                    end
                    if (!h) begin
                        dv_busy = 1'b1;
                        dv_left = $urandom_range(1, 6);
                    end
                end
            end

            // request acceptance
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                req_t r;
                rsp_t e;
                bit   id;
                id = req1_valid && req1_ready;
                if (id) r = rq1.pop_front();
                else    r = rq0.pop_front();
                grant_log.push_back(id);
                rr_ptr      = !id;
                outstanding = 1'b1;
                cur_id      = id;
                cur_n       = r.n;
                cur_d       = r.d;
                started     = 1'b0;
                e.id        = id;
`ifdef DIV_ZERO_CHECK_EN
                expect_start = (r.d != '0);
`else
                expect_start = 1'b1;
`endif
                if (!expect_start) begin
                    e.q = '1; e.r = r.n; e.err = 1'b1;
                end else if (r.hang) begin
                    e.q = '0; e.r = '0; e.err = 1'b1;
                end else if (r.d == '0) begin
                    e.q = '1; e.r = r.n; e.err = 1'b0;
                end else begin
                    e.q = r.n / r.d; e.r = r.n % r.d; e.err = 1'b0;
                end
                exp_q.push_back(e);
                if (expect_start) hang_q.push_back(r.hang);
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int cyc = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || outstanding) && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        chk(name, W'(cyc >= budget), W'(0));
        repeat (2) @(posedge clk);
    endtask

    task automatic push(input bit port, input logic [W-1:0] n, input logic [W-1:0] d, input bit hang);
        req_t r;
        r.n = n; r.d = d; r.hang = hang;
        if (port) rq1.push_back(r);
        else      rq0.push_back(r);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", W'({rsp1_valid, rsp0_valid}), '0);
        chk("rst_req_ready", W'({req1_ready, req0_ready}), '0);
        chk("rst_div_start", W'(div_start), '0);
        chk("rst_rsp_q", rsp_q, '0);
        chk("rst_rsp_r", rsp_r, '0);
        chk("rst_rsp_err", W'(rsp_err), '0);
        chk("rst_div_q_in", div_q_in, '0);
        chk("rst_div_m_in", div_m_in, '0);
        @(posedge clk);
        #1;

        push(1'b0, 64'd100, 64'd7, 1'b0);
        wait_idle("wait_single", 200);

        push(1'b0, 64'd55, 64'd0, 1'b0);
        wait_idle("wait_div_zero", 200);

        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, rnd_w(), {32'd0, $urandom}, 1'b0);
            push(1'b1, rnd_w(), {32'd0, $urandom}, 1'b0);
        end
        wait_idle("wait_contention", 500);
        chk("contention_grants", W'(grant_log.size()), W'(8));
        for (int i = 1; i < grant_log.size(); i++)
            chk("contention_alternate", W'(grant_log[i] == grant_log[i-1]), W'(0));

        push(1'b1, rnd_w(), 64'd3, 1'b1);
        wait_idle("wait_timeout", 200);

        bp1 = 1'b1;
        push(1'b1, rnd_w(), 64'd9, 1'b0);
        begin
            int cyc = 0;
            while (!rsp1_valid && cyc < 100) begin
                @(posedge clk);
                cyc++;
            end
            chk("bp_rsp1_seen", W'(cyc >= 100), W'(0));
        end
        repeat (20) @(posedge clk);
        #1 bp1 = 1'b0;
        wait_idle("wait_backpressure", 200);

        push(1'b0, rnd_w(), 64'd5, 1'b1);
        begin
            int cyc = 0;
            while (!started && cyc < 100) begin
                @(posedge clk);
                cyc++;
            end
            chk("rstwait_started", W'(cyc >= 100), W'(0));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstwait_idle_valid", W'({rsp1_valid, rsp0_valid}), '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] n, d;
            n = rnd_w();
            case ($urandom_range(0, 3))
                0:       d = '0;
                1:       d = {56'd0, 8'($urandom)};
                2:       d = {32'd0, $urandom};
                default: d = rnd_w();
            endcase
            push(1'($urandom_range(0, 1)), n, d, ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #1;
        end
        wait_idle("wait_random", 20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
